crypto_arbiter: RTL and testbench

CRYPTO_ARBITER -- requirements
Module: crypto_arbiter

---
 rtl/crypto_arbiter.sv | 126 ++++++++++++
 tb/tb_crypto_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/crypto_arbiter.sv
// Round-robin arbiter sharing one crypto core between two requesters, with a watchdog that aborts hung ops.
// Grant/enable one cycle after a sampled request; requests simply wait while busy; done/err are one-cycle pulses.
module crypto_arbiter #(
    parameter logic [15:0] TIMEOUT = 16'd1000
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [1:0] req,
    input  logic [1:0] req_e_or_d,
    input  logic [1:0] irq_resp_in,
    input  logic       core_ready,
    input  logic       core_irq,
    output logic       core_enable,
    output logic       core_e_or_d,
    output logic       core_irq_resp,
    output logic       core_abort,
    output logic [1:0] grant,
    output logic [1:0] irq_out,
    output logic [1:0] done,
    output logic [1:0] err,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        RUN,
        RELEASE,
        ABORT
    } state_t;

    state_t      r_state;
    logic [1:0]  r_grant;
    logic [1:0]  r_done;
    logic [1:0]  r_err;
    logic        r_last;
    logic        r_en;
    logic        r_mode;
    logic        r_abort;
    logic [15:0] r_cnt;

    logic [1:0]  w_win;
    logic        w_timeout;

    // r_last records the index of the previous winner; a tie goes to the other one.
    always_comb begin
        w_win = 2'b00;
        case (req)
            2'b01:   w_win = 2'b01;
            2'b10:   w_win = 2'b10;
            2'b11:   w_win = r_last ? 2'b01 : 2'b10;
            default: w_win = 2'b00;
        endcase
    end

    assign w_timeout = (r_cnt == TIMEOUT);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state <= IDLE;
            r_grant <= 2'b00;
            r_done  <= 2'b00;
            r_err   <= 2'b00;
            r_last  <= 1'b1;
            r_en    <= 1'b0;
            r_mode  <= 1'b0;
            r_abort <= 1'b0;
            r_cnt   <= 16'd0;
        end else begin
            r_done  <= 2'b00;
            r_err   <= 2'b00;
            r_abort <= 1'b0;
            case (r_state)
                IDLE: begin
                    if ((req != 2'b00) && core_ready) begin
                        r_grant <= w_win;
                        r_last  <= w_win[1];
                        r_mode  <= |(req_e_or_d & w_win);
                        r_en    <= 1'b1;
                        r_cnt   <= 16'd0;
                        r_state <= LAUNCH;
                    end
                end
                LAUNCH, RUN: begin
                    // Cycles spent waiting on the core's interrupt are not charged to the watchdog.
                    if (!core_irq && (r_cnt != 16'hFFFF)) begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                    if (w_timeout) begin
                        r_en    <= 1'b0;
                        r_abort <= 1'b1;
                        r_err   <= r_grant;
                        r_state <= ABORT;
                    end else if ((r_state == LAUNCH) && !core_ready) begin
                        r_state <= RUN;
                    end else if ((r_state == RUN) && core_ready) begin
                        r_en    <= 1'b0;
                        r_done  <= r_grant;
                        r_state <= RELEASE;
                    end
                end
                RELEASE, ABORT: begin
                    r_grant <= 2'b00;
                    r_mode  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_grant <= 2'b00;
                    r_en    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign core_enable   = r_en;
    assign core_e_or_d   = r_mode;
    assign core_abort    = r_abort;
    assign grant         = r_grant;
    assign done          = r_done;
    assign err           = r_err;
    assign busy          = (r_state != IDLE);
    assign irq_out       = r_grant & {2{core_irq}};
    assign core_irq_resp = |(r_grant & irq_resp_in);

endmodule

// File: tb/tb_crypto_arbiter.sv
// Randomised bench for crypto_arbiter: each operation's outcome is predicted from the core waveform the bench drives.
module tb_crypto_arbiter;

    localparam logic [15:0] TO = 16'd20;

    logic       clk;
    logic       n_rst;
    logic [1:0] req;
    logic [1:0] req_e_or_d;
    logic [1:0] irq_resp_in;
    logic       core_ready;
    logic       core_irq;
    logic       core_enable;
    logic       core_e_or_d;
    logic       core_irq_resp;
    logic       core_abort;
    logic [1:0] grant;
    logic [1:0] irq_out;
    logic [1:0] done;
    logic [1:0] err;
    logic       busy;
    logic [12:0] obs;

    int n_vec;
    int n_bad;
    bit m_last;

    crypto_arbiter #(.TIMEOUT(TO)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .req           (req),
        .req_e_or_d    (req_e_or_d),
        .irq_resp_in   (irq_resp_in),
        .core_ready    (core_ready),
        .core_irq      (core_irq),
        .core_enable   (core_enable),
        .core_e_or_d   (core_e_or_d),
        .core_irq_resp (core_irq_resp),
        .core_abort    (core_abort),
        .grant         (grant),
        .irq_out       (irq_out),
        .done          (done),
        .err           (err),
        .busy          (busy)
    );

    assign obs = {grant, core_enable, core_e_or_d, core_irq_resp, core_abort, irq_out, done, err, busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One operation. Cycle 0 is the IDLE cycle in which the request is sampled; cycle k>=1 follows the k-th edge.
    // Core model: ready high for t_drop cycles, low for t_run cycles, then high; irq high for cycles [irq_at, irq_at+irq_len).
    task automatic run_op(input logic [1:0] rq, input logic [1:0] md, input int t_drop, input int t_run,
                          input int irq_at, input int irq_len, input int drop_at, input int rst_at,
                          input string tag, output logic [1:0] g_seen);
        int idx, kr, kt, ke, cnt;
        bit ab, irq_k;
        logic [1:0] g, rq_now;
        logic mode;
        logic [12:0] exp_v;
        idx  = (rq == 2'b11) ? (m_last ? 0 : 1) : (rq[1] ? 1 : 0);
        g    = (idx == 1) ? 2'b10 : 2'b01;
        mode = md[idx];
        // Completion is seen in the first cycle ready is high again after having been low.
        kr   = t_drop + t_run + 1;
        // Timeout is seen in the first cycle by which TO non-irq cycles have elapsed; it wins a tie.
        cnt = 0;
        kt  = 0;
        for (int k = 1; k <= kr && kt == 0; k++) begin
            if (cnt == int'(TO)) kt = k;
            else if (!(k >= irq_at && k < irq_at + irq_len)) cnt++;
        end
        ab = (kt != 0);
        ke = ab ? kt : kr;
        m_last = (idx == 1);
        g_seen = 2'b00;

        req = rq; req_e_or_d = md; core_ready = 1'b1; core_irq = 1'b0;
        irq_resp_in = 2'($urandom_range(0, 3));
        @(negedge clk);
        n_vec++;
        if (obs !== 13'd0) begin
            n_bad++;
            $display("FAIL %s idle-before-grant: got %b want %b", tag, obs, 13'd0);
        end
        @(posedge clk); #1;
        for (int k = 1; k <= ke + 1; k++) begin
            irq_k = (k <= ke) && (k >= irq_at) && (k < irq_at + irq_len);
            core_ready = (k <= t_drop) || (k > t_drop + t_run) || (k > ke);
            core_irq = irq_k;
            irq_resp_in = 2'($urandom_range(0, 3));
            rq_now = rq | 2'($urandom_range(0, 3));
            rq_now[idx] = !(drop_at > 0 && k >= drop_at);
            req = rq_now;
            if (k <= ke)
                exp_v = {g, 1'b1, mode, irq_resp_in[idx], 1'b0, irq_k ? g : 2'b00, 2'b00, 2'b00, 1'b1};
            else
                exp_v = {g, 1'b0, mode, irq_resp_in[idx], ab, 2'b00, ab ? 2'b00 : g, ab ? g : 2'b00, 1'b1};
            if (rst_at == k) n_rst = 1'b0;
            @(negedge clk);
            if (k == 1) g_seen = grant;
            n_vec++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL %s cycle %0d: got %b want %b (grant,en,mode,irq_resp,abort,irq_out,done,err,busy)",
                         tag, k, obs, exp_v);
            end
            @(posedge clk); #1;
            if (rst_at == k) begin
                n_rst = 1'b1; req = 2'b00; core_ready = 1'b1; core_irq = 1'b0;
                m_last = 1'b1;
                @(negedge clk);
                n_vec++;
                if (obs !== 13'd0) begin
                    n_bad++;
                    $display("FAIL %s after-reset: got %b want %b", tag, obs, 13'd0);
                end
                @(posedge clk); #1;
                break;
            end
        end
        req = 2'b00;
    endtask

    task automatic test_reset();
        n_rst = 1'b0; req = 2'b11; req_e_or_d = 2'b11; irq_resp_in = 2'b11;
        core_ready = 1'b1; core_irq = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({grant, core_enable, core_e_or_d, core_abort, done, err, busy} !== 10'd0) begin
            n_bad++;
            $display("FAIL reset-state: got %b want %b", {grant, core_enable, core_e_or_d, core_abort, done, err, busy}, 10'd0);
        end
        @(posedge clk); #1;
        n_rst = 1'b1; req = 2'b00; core_irq = 1'b0;
        m_last = 1'b1;
        @(negedge clk);
        n_vec++;
        if (obs !== 13'd0) begin
            n_bad++;
            $display("FAIL reset-idle: got %b want %b", obs, 13'd0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        logic [1:0] gs;
        run_op(2'b01, 2'b01, 2, 15, 0, 0, 0, 0, "single", gs);
        @(negedge clk);
        n_vec++;
        if ({busy, grant, done} !== 5'd0) begin
            n_bad++;
            $display("FAIL single-busy-after: got %b want %b", {busy, grant, done}, 5'd0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_contention();
        logic [1:0] gs;
        logic [1:0] want [3];
        want[0] = 2'b01; want[1] = 2'b10; want[2] = 2'b01;
        n_rst = 1'b0;
        @(posedge clk); #1;
        n_rst = 1'b1;
        m_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run_op(2'b11, 2'($urandom_range(0, 3)), 1, $urandom_range(3, 8), 0, 0, 0, 0, "contend", gs);
            n_vec++;
            if (gs !== want[i]) begin
                n_bad++;
                $display("FAIL contend-seq op %0d: got %b want %b", i, gs, want[i]);
            end
        end
    endtask

    task automatic test_irq();
        logic [1:0] gs;
        run_op(2'b10, 2'($urandom_range(0, 3)), 2, 60, 5, 50, 0, 0, "irq", gs);
        n_vec++;
        if (gs !== 2'b10) begin
            n_bad++;
            $display("FAIL irq-owner: got %b want %b", gs, 2'b10);
        end
    endtask

    task automatic test_timeout();
        logic [1:0] gs;
        run_op(2'b01, 2'b00, 3, 1000, 0, 0, 0, 0, "timeout", gs);
        run_op(2'b10, 2'b10, 1, 1000, 5, 7, 0, 0, "timeout-irq", gs);
    endtask

    task automatic test_boundary();
        logic [1:0] gs;
        run_op(2'b01, 2'b01, 2, 18, 0, 0, 0, 0, "tie-abort", gs);
        run_op(2'b10, 2'b00, 2, 17, 0, 0, 0, 0, "just-done", gs);
        run_op(2'b01, 2'b10, 0, 1, 0, 0, 0, 0, "shortest", gs);
    endtask

    task automatic test_drop_req();
        logic [1:0] gs;
        run_op(2'b01, 2'b01, 2, 15, 0, 0, 6, 0, "drop-req", gs);
    endtask

    task automatic test_reset_mid_run();
        logic [1:0] gs;
        run_op(2'b10, 2'b11, 2, 15, 0, 0, 0, 8, "rst-mid-run", gs);
        run_op(2'b11, 2'b00, 1, 4, 0, 0, 0, 0, "rst-tie", gs);
        n_vec++;
        if (gs !== 2'b01) begin
            n_bad++;
            $display("FAIL rst-last-grant: got %b want %b", gs, 2'b01);
        end
    endtask

    task automatic test_random();
        logic [1:0] gs;
        int drop_at;
        for (int i = 0; i < 40; i++) begin
            drop_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 10)) : 0;
            run_op(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)), $urandom_range(0, 6),
                   $urandom_range(1, 25), $urandom_range(1, 30), $urandom_range(0, 10),
                   drop_at, 0, "random", gs);
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        m_last = 1'b1;
        test_reset();
        test_single();
        test_contention();
        test_irq();
        test_timeout();
        test_boundary();
        test_drop_req();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL bench-timeout: simulation exceeded its time budget");
        $fatal(1);
    end

endmodule
